// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: sequencer that wraps a 1W/1R block RAM with a registered read
// (1-cycle latency) into a first-word-fall-through FIFO with valid/ready on both sides.
// Capacity is DEPTH words in RAM plus a 2-entry output buffer that hides the read latency.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds o_almost_full / o_almost_empty.

// Simulation-time invariants of the controller.
module bram_fifo_ctrl_chk #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rstn,
  input logic              ready,
  input logic              wren,
  input logic [ADDR_W:0]   ram_cnt,
  input logic [1:0]        out_cnt,
  input logic              valid,
  input logic              down_ready,
  input logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W:0] RAM_FULL = (ADDR_W + 1)'(DEPTH);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn) wren |-> ready);
  a_ram_cnt_bound:     assert property (@(posedge clk) disable iff (!rstn) ram_cnt <= RAM_FULL);
  a_out_cnt_bound:     assert property (@(posedge clk) disable iff (!rstn) out_cnt <= 2'd2);
  a_head_stable:       assert property (@(posedge clk) disable iff (!rstn)
                                        (valid && !down_ready) |=> (valid && $stable(data)));

endmodule

module bram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL = DEPTH,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_ram_wren,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [CNT_W-1:0]  o_count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              o_almost_full,
  output logic              o_almost_empty
`endif
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bram_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [ADDR_W:0]   RAM_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   ram_cnt_r;
  logic [ADDR_W:0]   ram_cnt_n;
  logic              inflight_r;
  logic [1:0]        out_cnt_r;
  logic [1:0]        out_cnt_n;
  logic [DATA_W-1:0] buf0_r;
  logic [DATA_W-1:0] buf1_r;
  logic [DATA_W-1:0] buf0_n;
  logic [DATA_W-1:0] buf1_n;
  logic              ready_r;
  logic              valid_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_n;
  logic              push_s;
  logic              pop_s;
  logic              fetch_s;
  logic [2:0]        room_s;
  logic [1:0]        slot_s;

  // Handshakes use only registered state on the output side.
  assign push_s = i_valid & ready_r;
  assign pop_s  = valid_r & i_ready;

  // RAM write port is a straight pass-through of the upstream beat.
  assign o_ram_wren  = push_s;
  assign o_ram_waddr = wr_ptr_r;
  assign o_ram_wdata = i_data;
  assign o_ram_raddr = rd_ptr_r;

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_data  = buf0_r;
  assign o_count = count_r;

  // Fetch decision: read the RAM only when the buffer will have a free slot for the returning word.
  always_comb begin
    room_s  = {1'b0, out_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    fetch_s = (ram_cnt_r != {(ADDR_W + 1){1'b0}}) && (room_s < 3'd2);
  end

  // RAM occupancy: only completed writes count, so a fetch never races the same-cycle write.
  always_comb begin
    ram_cnt_n = ram_cnt_r;
    case ({push_s, fetch_s})
      2'b10:   ram_cnt_n = ram_cnt_r + CNT_ONE;
      2'b01:   ram_cnt_n = ram_cnt_r - CNT_ONE;
      default: ram_cnt_n = ram_cnt_r;
    endcase
  end

  // Output buffer: shift on pop, then land the in-flight read word in the first free slot.
  always_comb begin
    buf0_n    = buf0_r;
    buf1_n    = buf1_r;
    slot_s    = out_cnt_r - {1'b0, pop_s};
    out_cnt_n = out_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    if (pop_s) begin
      buf0_n = buf1_r;
    end else begin
      buf0_n = buf0_r;
    end
    if (inflight_r) begin
      if (slot_s == 2'd0) begin
        buf0_n = i_ram_rdata;
      end else begin
        buf1_n = i_ram_rdata;
      end
    end else begin
      buf1_n = buf1_r;
    end
  end

  // Total occupancy after this edge: RAM words, the word being read, and buffered words.
  always_comb begin
    count_n = CNT_W'(ram_cnt_n) + CNT_W'(fetch_s) + CNT_W'(out_cnt_n);
  end

  // Pointer, occupancy and output-buffer state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      ram_cnt_r  <= {(ADDR_W + 1){1'b0}};
      inflight_r <= 1'b0;
      out_cnt_r  <= 2'd0;
      buf0_r     <= {DATA_W{1'b0}};
      buf1_r     <= {DATA_W{1'b0}};
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (fetch_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      ram_cnt_r  <= ram_cnt_n;
      inflight_r <= fetch_s;
      out_cnt_r  <= out_cnt_n;
      buf0_r     <= buf0_n;
      buf1_r     <= buf1_n;
      ready_r    <= (ram_cnt_n != RAM_FULL);
      valid_r    <= (out_cnt_n != 2'd0);
      count_r    <= count_n;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // Threshold flags follow the registered count on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      o_almost_full  <= (count_n >= CNT_W'(AF_LEVEL));
      o_almost_empty <= (count_n <= CNT_W'(AE_LEVEL));
    end
  end
`endif

  bram_fifo_ctrl_chk #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .ready      (ready_r),
    .wren       (o_ram_wren),
    .ram_cnt    (ram_cnt_r),
    .out_cnt    (out_cnt_r),
    .valid      (valid_r),
    .down_ready (i_ready),
    .data       (buf0_r)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a 1-clk registered-read RAM model.
module tb_bram_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_ram_wren;
  logic [ADDR_W-1:0] o_ram_waddr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [ADDR_W-1:0] o_ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  o_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic              o_almost_full;
  logic              o_almost_empty;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] model_q[$];
  int                wr_cnt = 0;
  int                pops = 0;
  bit                first_seen = 1'b0;
  logic [DATA_W-1:0] first_out = '0;
  int                next_data = 0;
  int                data_end = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_ram_wren  (o_ram_wren),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .o_ram_raddr (o_ram_raddr),
    .i_ram_rdata (ram_rdata),
    .o_count     (o_count)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty)
`endif
  );

  // Block RAM model: one write port, registered read.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (o_ram_wren) mem[o_ram_waddr] <= o_ram_wdata;
    ram_rdata <= mem[o_ram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT behaviour each cycle against the queue model.
  always @(negedge clk) begin
    if (rstn) begin
      chk("count", 32'(o_count), 32'(model_q.size()));
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("almost_full", 32'(o_almost_full), 32'(model_q.size() >= 8));
      chk("almost_empty", 32'(o_almost_empty), 32'(model_q.size() <= 2));
`endif
      chk("wren", 32'(o_ram_wren), 32'(i_valid & o_ready));
      if (o_ram_wren) begin
        chk("waddr", 32'(o_ram_waddr), 32'(wr_cnt % DEPTH));
        chk("wdata", 32'(o_ram_wdata), 32'(i_data));
      end
      if (model_q.size() == 0) begin
        chk("valid_when_empty", 32'(o_valid), 32'd0);
      end else if (o_valid && i_ready) begin
        logic [DATA_W-1:0] exp_d;
        exp_d = model_q.pop_front();
        chk("data", 32'(o_data), 32'(exp_d));
        pops++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_out  = o_data;
        end
      end
      if (i_valid && o_ready) begin
        model_q.push_back(i_data);
        wr_cnt++;
      end
    end
  end

  // Random driver: i_valid/i_ready with given percentages, data advances on acceptance.
  task automatic run(input int n, input int vpct, input int rpct);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      i_valid = (next_data < data_end) && ($urandom_range(99) < vpct);
      i_data  = next_data[7:0];
      i_ready = ($urandom_range(99) < rpct);
      if (i_valid && o_ready) next_data++;
    end
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      if (model_q.size() == 0 && !o_valid) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdrops;
    int vgaps;
    int start;
    int pops0;
    void'($urandom(32'h1234));

    // Reset state, with a request present so wren gating is exercised.
    rstn = 1'b0; i_valid = 1'b1; i_data = 8'h3C; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_wren", 32'(o_ram_wren), 32'd0);
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("rst_afull", 32'(o_almost_full), 32'd0);
    chk("rst_aempty", 32'(o_almost_empty), 32'd1);
`endif
    @(posedge clk); #1;
    rstn = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(o_ready), 32'd1);

    // 1: single word latency.
    i_data = 8'hA5; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    chk("t1_valid_c1", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_c2", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_c3", 32'(o_valid), 32'd1);
    chk("t1_data", 32'(o_data), 32'hA5);
    @(posedge clk); #1;
    chk("t1_valid_c4", 32'(o_valid), 32'd0);
    chk("t1_count_c4", 32'(o_count), 32'd0);

    // 2: fill with consumer stalled.
    next_data = 0; data_end = 12;
    run(20, 100, 0);
    chk("t2_accepted", 32'(next_data), 32'd10);
    chk("t2_ready_low", 32'(o_ready), 32'd0);
    chk("t2_count", 32'(o_count), 32'd10);
    drain(100);

    // 3: streaming push/pop every cycle.
    start = 32'h100; next_data = start; data_end = 32'h1000;
    rdrops = 0; vgaps = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_ready = 1'b1; i_data = next_data[7:0];
      if (!o_ready) rdrops++; else next_data++;
      if (c >= 3 && !o_valid) vgaps++;
    end
    chk("t3_ready_drops", 32'(rdrops), 32'd0);
    chk("t3_valid_gaps", 32'(vgaps), 32'd0);
    chk("t3_pushed", 32'(next_data - start), 32'd100);
    drain(100);

    // 4: random handshakes across pointer wraps.
    pops0 = pops;
    next_data = 32'h10; data_end = 32'h24;
    for (int c = 0; c < 400 && next_data < data_end; c++) run(1, 60, 60);
    drain(200);
    chk("t4_pops", 32'(pops - pops0), 32'd20);

    // 5: asynchronous reset with data held.
    next_data = 32'h50; data_end = 32'h56;
    run(12, 100, 0);
    chk("t5_count_pre", 32'(o_count), 32'd6);
    chk("t5_valid_pre", 32'(o_valid), 32'd1);
    @(posedge clk); #3;
    i_valid = 1'b1; rstn = 1'b0;
    #1;
    chk("t5_valid_rst", 32'(o_valid), 32'd0);
    chk("t5_count_rst", 32'(o_count), 32'd0);
    chk("t5_wren_rst", 32'(o_ram_wren), 32'd0);
    chk("t5_ready_rst", 32'(o_ready), 32'd0);
    model_q.delete();
    wr_cnt = 0;
    first_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_ready_after", 32'(o_ready), 32'd1);
    next_data = 32'h77; data_end = 32'h7A;
    run(3, 100, 100);
    drain(100);
    chk("t5_first_seen", 32'(first_seen), 32'd1);
    chk("t5_first_word", 32'(first_out), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
